// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the SRAM-port responder (data_sram_resp).
// Optional feature macro: SRAM_RESP_BYTE_WE_EN widens sram_we to per-byte strobes.
package sram_resp_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR_DEFAULT = 32'h1C00_0000;
  localparam int          SRAM_READ_LAT_MIN      = 1;
  localparam int          SRAM_READ_LAT_MAX      = 4;

`ifdef SRAM_RESP_BYTE_WE_EN
  localparam int SRAM_WE_W = 4;
`else
  localparam int SRAM_WE_W = 1;
`endif

  // Payload carried from the accept edge to the response edge.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic        is_wr;
    logic [31:0] data;
  } sram_resp_t;

  // Width of {err, is_wr, data} as it travels through the delay pipe.
  localparam int SRAM_RESP_PAYLOAD_W = 34;

  // True when addr falls inside [base, base + span_bytes). The subtraction
  // wraps, so the explicit lower-bound compare rejects addresses below base.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < span_bytes);
  endfunction

endpackage

// File: rtl/sram_resp_pipe.sv
// Fixed-depth valid/data shift pipe with synchronous flush. STAGES=0 is a
// plain wire-through so the top can use it unconditionally.
module sram_resp_pipe #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 34
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass_s;
      assign unused_bypass_s = clk ^ flush;
      assign out_valid       = in_valid;
      assign out_data        = in_data;
    end else begin : g_shift
      logic [STAGES-1:0] valid_q;
      logic [STAGES-1:0] valid_d;
      logic [WIDTH-1:0]  data_q [STAGES];
      logic [WIDTH-1:0]  data_d [STAGES];

      // Each stage takes the contents of the stage before it.
      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end

      // Stage registers; flush drops everything in flight.
      always_ff @(posedge clk) begin
        if (flush) begin
          valid_q <= {STAGES{1'b0}};
          for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= {WIDTH{1'b0}};
          end
        end else begin
          valid_q <= valid_d;
          for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
          end
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the CPU SRAM-style port: word RAM, READ_LAT-cycle response
// pipe, rvalid/err strobes and saturating in-range access counters.
// Optional feature macro: SRAM_RESP_BYTE_WE_EN (4-bit byte-lane sram_we).
// READ_LAT is legal in SRAM_READ_LAT_MIN..SRAM_READ_LAT_MAX.
module data_sram_resp
  import sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR_DEFAULT,
  parameter int          DEPTH     = 4096,
  parameter int          READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sram_en,
  input  logic [SRAM_WE_W-1:0] sram_we,
  input  logic [31:0]          sram_addr,
  input  logic [31:0]          sram_wdata,
  output logic [31:0]          sram_rdata,
  output logic                 sram_rvalid,
  output logic                 sram_err,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] SPAN_BYTES  = 32'(DEPTH * 4);
  localparam int          PIPE_STAGES = READ_LAT - 1;

  logic [31:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic          accept_s;
  logic [3:0]    mem_we_s;
  sram_resp_t    req_s;
  sram_resp_t    resp_s;
  logic          pipe_valid_s;
  logic [SRAM_RESP_PAYLOAD_W-1:0] pipe_data_s;
  logic          unused_off_s;

  logic [31:0] mem_q [DEPTH];

  logic        rvalid_q, rvalid_d;
  logic        err_q,    err_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Request decode: range check, word index, byte lanes and RAM read sample.
  always_comb begin
    off_s      = sram_addr - BASE_ADDR;
    in_range_s = addr_in_range(sram_addr, BASE_ADDR, SPAN_BYTES);
    idx_s      = off_s[AW+1:2];
`ifdef SRAM_RESP_BYTE_WE_EN
    be_s       = sram_we;
`else
    be_s       = {4{sram_we[0]}};
`endif
    accept_s   = sram_en & ~reset;
    if (accept_s && in_range_s) begin
      mem_we_s = be_s;
    end else begin
      mem_we_s = 4'b0000;
    end
    req_s.valid = accept_s;
    req_s.err   = ~in_range_s;
    req_s.is_wr = |be_s;
    req_s.data  = mem_q[idx_s];
  end

  assign unused_off_s = ^{off_s[1:0], off_s[31:AW+2]};

  // RAM write port; contents are intentionally kept across reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_s[b]) begin
        mem_q[idx_s][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  sram_resp_pipe #(
    .STAGES (PIPE_STAGES),
    .WIDTH  (SRAM_RESP_PAYLOAD_W)
  ) u_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (req_s.valid),
    .in_data   ({req_s.err, req_s.is_wr, req_s.data}),
    .out_valid (pipe_valid_s),
    .out_data  (pipe_data_s)
  );

  // Response stage: strobes, rdata capture on good reads, saturating counters.
  always_comb begin
    resp_s.valid = pipe_valid_s;
    resp_s.err   = pipe_data_s[33];
    resp_s.is_wr = pipe_data_s[32];
    resp_s.data  = pipe_data_s[31:0];
    rvalid_d     = resp_s.valid;
    err_d        = resp_s.valid & resp_s.err;
    rdata_d      = rdata_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    if (resp_s.valid && !resp_s.err) begin
      if (resp_s.is_wr) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end else begin
        rdata_d = resp_s.data;
        if (rd_cnt_q != 32'hFFFF_FFFF) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rd_cnt_q <= 32'h0000_0000;
      wr_cnt_q <= 32'h0000_0000;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign sram_rvalid = rvalid_q;
  assign sram_err    = err_q;
  assign sram_rdata  = rdata_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the CPU's SRAM-style data/instruction port (we/addr/wdata/rdata); answers the initiator's requests.
- Word-organised synchronous RAM with a programmable read-latency pipeline, a response-valid strobe, an out-of-range error flag, and access counters.
- Instantiated in the SoC-lite wrapper beside mycpu_top.
- Used for both inst and data sides; the inst instance ties we low.

Parameters:
- BASE_ADDR, 32'h1C00_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words (power of two, ≥16).
- READ_LAT, 1, cycles from request accept to response (legal 1..4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sram_en  in  1  request valid; one request accepted per cycle; no backpressure.
- sram_we  in  1  write request when sram_en=1 (4 bits with SRAM_RESP_BYTE_WE_EN).
- sram_addr  in  32  byte address; bits [1:0] ignored.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data; valid when sram_rvalid=1; holds last value otherwise.
- sram_rvalid  out  1  one-cycle response strobe, READ_LAT cycles after accept.
- sram_err  out  1  qualifies sram_rvalid; 1 = address out of range.
- rd_cnt  out  32  completed in-range reads.
- wr_cnt  out  32  completed in-range writes.

Behaviour:
- Reset values:
  - sram_rdata=0, sram_rvalid=0, sram_err=0, rd_cnt=0, wr_cnt=0.
  - All pipeline stages are invalidated.
  - RAM contents are NOT cleared; they are retained across reset.
- Decode:
  - off = sram_addr − BASE_ADDR (32-bit wrap).
  - in_range = (sram_addr ≥ BASE_ADDR) && (off < DEPTH*4).
  - idx = off[log2(DEPTH)+1:2].
- Accept: any cycle with sram_en=1 and reset=0. Requests with sram_en=0 are ignored, and no response is generated for them.
- Write (we≠0, in_range): mem[idx] is updated at the accept edge.
  - The response carries rdata = previous sram_rdata (unchanged) and err=0.
  - wr_cnt increments at response time.
- Read (we=0, in_range): mem[idx] is sampled at the accept edge.
  - The value is carried through READ_LAT−1 further register stages.
  - rd_cnt increments at response time.
- Out-of-range read or write:
  - No RAM access occurs.
  - The response has err=1, and rdata is unchanged.
  - No counter increments.
- Latency: a request accepted at edge t produces rvalid high in the cycle after edge t+READ_LAT−1. With READ_LAT=1, rdata appears the cycle after the request, as the multicycle core expects.
- Throughput: back-to-back requests produce back-to-back responses, in order. The pipeline is a pure shift register, so it never stalls.
- Read-after-write to the same word in consecutive cycles returns the new data.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- Reset mid-operation: all in-flight responses are dropped (no rvalid after reset), and the counters are zeroed.
- sram_addr == BASE_ADDR+DEPTH*4−4 is in range; BASE_ADDR+DEPTH*4 is out of range.
- Addresses below BASE_ADDR are out of range, including the wrap case.

Optional Feature:
- Macro: SRAM_RESP_BYTE_WE_EN.
- Defined:
  - sram_we is 4 bits.
  - For each set bit i, only mem[idx][8i+7:8i] is written from sram_wdata[8i+7:8i].
  - A request counts as a write if any bit is set.
- Undefined:
  - sram_we is 1 bit.
  - A write replaces the whole word.

Decomposition:
- Package sram_resp_pkg holds:
  - BASE_ADDR default, and READ_LAT min/max constants.
  - Response struct {valid, err, is_wr, data[31:0]}.
  - Function addr_in_range().
- Sub-module sram_resp_pipe: parameterised-depth valid/data shift pipe with synchronous flush. It is used for the READ_LAT−1 delay stages; it is omitted (depth 0) when READ_LAT=1.

Test Plan:
- Read after write: write 0x1C00_0010 ← 0xDEAD_BEEF, then read the same address next cycle → rdata=0xDEAD_BEEF, rvalid one cycle after the read, err=0; wr_cnt=1, rd_cnt=1.
- Streaming reads: READ_LAT=3, reads to words 0,1,2 in consecutive cycles (preloaded 0x11,0x22,0x33) → rvalid high for three consecutive cycles starting 3 cycles after the first request; data 0x11,0x22,0x33 in order.
- Range boundaries:
  - Read 0x1C00_3FFC (DEPTH=4096) → err=0.
  - Read 0x1C00_4000 → rvalid=1, err=1, rdata unchanged, rd_cnt unchanged.
  - Read 0x1BFF_FFFC → err=1.
- Reset mid-flight: READ_LAT=4, issue a read, assert reset for 1 cycle at cycle 2 → no rvalid ever; counters=0; a prior write at 0x1C00_0000 still reads back after reset.
- Byte strobes (SRAM_RESP_BYTE_WE_EN): word=0x1122_3344, write we=4'b0101, wdata=0xAABB_CCDD → readback 0x11BB_33DD. Undefined build: we=1 with wdata=0xAABB_CCDD → readback 0xAABB_CCDD.
- Idle and mixed: sram_en=0 with we=1 for 10 cycles → no RAM change, no rvalid. Alternating read/write for 8 cycles → rd_cnt=4, wr_cnt=4.
